// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the RAM sequencer/arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEFAULT = 4;
    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and loader requesters.
// MEM_ARB_RR_EN defined: round-robin on ties (requester not granted last wins).
// MEM_ARB_RR_EN undefined: fixed priority, loader over CPU.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    cpu_elig,
    input  logic    ld_elig,
`ifdef MEM_ARB_RR_EN
    input  req_id_t last_grant,
`endif
    output logic    grant_valid,
    output req_id_t grant_id
);

    // Pick one eligible requester; grant_id is don't-care when nothing is eligible.
    always_comb begin
        grant_valid = cpu_elig | ld_elig;
        grant_id    = REQ_CPU;
`ifdef MEM_ARB_RR_EN
        if (cpu_elig && ld_elig) begin
            grant_id = (last_grant == REQ_CPU) ? REQ_LD : REQ_CPU;
        end else if (ld_elig) begin
            grant_id = REQ_LD;
        end
`else
        if (ld_elig) begin
            grant_id = REQ_LD;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the single-port program RAM shared by the CPU bus
// and the program loader. Each access is IDLE -> ACCESS -> ACK.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (adds a
// last-grant register); otherwise the loader has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_mode,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] mem_address,
    output logic          ri,
    output logic          ro,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t  state;
    state_t  state_nxt;
    req_id_t id_q;
    logic    we_q;
    logic    cpu_elig;
    logic    ld_elig;
    logic    grant_valid;
    req_id_t grant_id;
    logic    grant;

    assign cpu_elig = cpu_req & ~prog_mode;
    assign ld_elig  = ld_req;
    assign grant    = (state == IDLE) && grant_valid;

`ifdef MEM_ARB_RR_EN
    req_id_t last_grant;

    // Remember who won most recently so ties alternate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_CPU;
        end else if (grant) begin
            last_grant <= grant_id;
        end
    end
`endif

    mem_arb_pick u_pick (
        .cpu_elig    (cpu_elig),
        .ld_elig     (ld_elig),
`ifdef MEM_ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; strobes are pure state decode so a
    // reset in ACCESS drops ri/ro immediately.
    always_comb begin
        state_nxt = state;
        ri        = 1'b0;
        ro        = 1'b0;
        cpu_ack   = 1'b0;
        ld_ack    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ri        = we_q;
                ro        = ~we_q;
                state_nxt = ACK;
            end
            ACK: begin
                cpu_ack   = (id_q == REQ_CPU);
                ld_ack    = (id_q == REQ_LD);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's payload on grant; RAM address/data come straight
    // from these registers so they only change on entry to ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q        <= REQ_CPU;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else if (grant) begin
            id_q <= grant_id;
            if (grant_id == REQ_LD) begin
                we_q        <= ld_we;
                mem_address <= ld_addr;
                mem_wdata   <= ld_wdata;
            end else begin
                we_q        <= cpu_we;
                mem_address <= cpu_addr;
                mem_wdata   <= cpu_wdata;
            end
        end
    end

    // Capture read data into the winner's register at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else if ((state == ACCESS) && !we_q) begin
            if (id_q == REQ_LD) begin
                ld_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 16x8 RAM.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       prog_mode;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       ld_req, ld_we, ld_ack;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata, ld_rdata;
    logic [3:0] mem_address;
    logic       ri, ro, busy;
    logic [7:0] mem_wdata, mem_rdata;

    mem_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_address(mem_address), .ri(ri), .ro(ro),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model
    logic [7:0] ram [16];
    logic       ram_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_done) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
            ram_done <= 1'b1;
        end else if (ri) begin
            ram[mem_address] <= mem_wdata;
        end
    end
    assign mem_rdata = ro ? ram[mem_address] : 'z;

    typedef struct {
        bit         ld;
        bit         chk;
        logic [7:0] data;
        int         ack_edge;
    } exp_t;

    exp_t       scb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         ri_cnt   = 0;
    int         ro_cnt   = 0;
    int         both_hi  = 0;
    logic [3:0] last_ri_addr = '0;
    logic [7:0] last_ri_data = '0;
    bit         cpu_hold = 0;
    bit         ld_hold  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input bit ld, input bit c, input logic [7:0] d, input int e);
        exp_t x;
        x.ld = ld; x.chk = c; x.data = d; x.ack_edge = e;
        scb.push_back(x);
    endtask

    // One clock; a requester drops req on the edge where it sees its ack.
    task automatic step();
        bit c, l;
        @(negedge clk);
        c = cpu_ack;
        l = ld_ack;
        @(posedge clk);
        #1;
        if (c && !cpu_hold) cpu_req = 1'b0;
        if (l && !ld_hold)  ld_req  = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cpu_issue(input bit we, input logic [3:0] a, input logic [7:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic ld_issue(input bit we, input logic [3:0] a, input logic [7:0] d);
        ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1'b1;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: strobe bookkeeping and scoreboard compare on every ack.
    initial forever begin
        exp_t e;
        bit   got_ld;
        logic [7:0] got_d;
        @(negedge clk);
        if (!rst) begin
            if (ri && ro) both_hi++;
            if (ri) begin
                ri_cnt++;
                last_ri_addr = mem_address;
                last_ri_data = mem_wdata;
            end
            if (ro) ro_cnt++;
            if (cpu_ack || ld_ack) begin
                checks++;
                got_ld = ld_ack;
                got_d  = ld_ack ? ld_rdata : cpu_rdata;
                if (cpu_ack && ld_ack) begin
                    failures++;
                    $display("FAIL dual_ack: both acks high at edge %0d", cyc + 1);
                end else if (scb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: port_ld=%0d edge=%0d, none expected", got_ld, cyc + 1);
                end else begin
                    e = scb.pop_front();
                    if (got_ld != e.ld || (cyc + 1) != e.ack_edge || (e.chk && got_d !== e.data)) begin
                        failures++;
                        $display("FAIL ack: got port_ld=%0d edge=%0d data=%h, want port_ld=%0d edge=%0d data=%h",
                                 got_ld, cyc + 1, got_d, e.ld, e.ack_edge, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int k, r0, i0;
        rst = 1'b1; prog_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ri", ri, 0);
        chk("rst_ro", ro, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ld_ack", ld_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Read of never-written address 9
        k = cyc; r0 = ro_cnt; i0 = ri_cnt;
        cpu_issue(1'b0, 4'd9, 8'h00);
        push(0, 1, 8'h00, k + 3);
        steps(4);
        chk("rd9_ro_cycles", ro_cnt - r0, 1);
        chk("rd9_ri_cycles", ri_cnt - i0, 0);
        chk("rd9_rdata", cpu_rdata, 8'h00);
        chk("rd9_busy_idle", busy, 0);

        // CPU write 0x5A to 3, then read back
        k = cyc; r0 = ro_cnt; i0 = ri_cnt;
        cpu_issue(1'b1, 4'd3, 8'h5A);
        push(0, 0, 8'h00, k + 3);
        steps(3);
        chk("wr3_ri_cycles", ri_cnt - i0, 1);
        chk("wr3_ro_cycles", ro_cnt - r0, 0);
        chk("wr3_addr", last_ri_addr, 4'd3);
        chk("wr3_data", last_ri_data, 8'h5A);
        k = cyc;
        cpu_issue(1'b0, 4'd3, 8'h00);
        push(0, 1, 8'h5A, k + 3);
        steps(3);
        chk("rd3_rdata", cpu_rdata, 8'h5A);

        // Simultaneous loader write 7<=0x11 and CPU read 7: loader wins
        k = cyc;
        ld_issue(1'b1, 4'd7, 8'h11);
        cpu_issue(1'b0, 4'd7, 8'h00);
        push(1, 0, 8'h00, k + 3);
        push(0, 1, 8'h11, k + 6);
        steps(7);
        chk("sim_cpu_rdata", cpu_rdata, 8'h11);

        // Both requesting continuously for 12 cycles
        k = cyc;
        cpu_hold = 1; ld_hold = 1;
        ld_issue(1'b1, 4'd8, 8'h22);
        cpu_issue(1'b0, 4'd8, 8'h00);
`ifdef MEM_ARB_RR_EN
        push(1, 0, 8'h00, k + 3);
        push(0, 1, 8'h22, k + 6);
        push(1, 0, 8'h00, k + 9);
        push(0, 1, 8'h22, k + 12);
`else
        push(1, 0, 8'h00, k + 3);
        push(1, 0, 8'h00, k + 6);
        push(1, 0, 8'h00, k + 9);
        push(1, 0, 8'h00, k + 12);
`endif
        steps(12);
        cpu_hold = 0; ld_hold = 0;
        cpu_req = 1'b0; ld_req = 1'b0;
        steps(2);
        chk("cont_busy_idle", busy, 0);

        // prog_mode: loader fills 0..15 while CPU read of 15 is held off
        prog_mode = 1'b1;
        cpu_issue(1'b0, 4'd15, 8'h00);
        for (int i = 0; i < 16; i++) begin
            ld_issue(1'b1, 4'(i), 8'(i));
            push(1, 0, 8'h00, cyc + 3);
            steps(3);
        end
        chk("pm_cpu_still_req", cpu_req, 1);
        prog_mode = 1'b0;
        k = cyc;
        push(0, 1, 8'h0F, k + 3);
        steps(4);
        chk("pm_rd15_rdata", cpu_rdata, 8'h0F);

        // Reset in the ACCESS cycle of a CPU write
        cpu_issue(1'b1, 4'd5, 8'h77);
        @(posedge clk);
        #1;
        chk("rstacc_ri_before", ri, 1);
        chk("rstacc_addr", mem_address, 4'd5);
        #1 rst = 1'b1;
        #1;
        chk("rstacc_ri_async", ri, 0);
        chk("rstacc_ro_async", ro, 0);
        chk("rstacc_no_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstacc_busy_after", busy, 0);
        chk("rstacc_rdata_cleared", cpu_rdata, 8'h00);
        k = cyc; i0 = ri_cnt;
        cpu_issue(1'b1, 4'd5, 8'h77);
        push(0, 0, 8'h00, k + 3);
        steps(3);
        chk("rewr5_ri_cycles", ri_cnt - i0, 1);
        k = cyc;
        cpu_issue(1'b0, 4'd5, 8'h00);
        push(0, 1, 8'h77, k + 3);
        steps(4);
        chk("rd5_rdata", cpu_rdata, 8'h77);

        steps(3);
        chk("scoreboard_drained", scb.size(), 0);
        chk("ri_ro_exclusive", both_hi, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
